board_commit_scheduler: RTL and testbench
=========================================

// Module: board_commit_scheduler
// PURPOSE
//  Sequences board updates from tetris_2048_core into the VGA renderer so the visible board changes only at vertical blanking.
//  Accepts a level commit request from the core and snapshots the board, spawn value and cursor column.
//  For drop moves, it first runs a frame-stepped fall animation of the spawned tile, then commits at vblank and acks the core.
//  Sits between tetris_2048_core and block_controller; replaces the raw display_ready gating.
// PARAMETERS
//  V_ACTIVE       480  vCount value at which vertical blanking begins
//  TILE_SIZE      30   tile edge in pixels
//  GAP_SIZE       4    gap between tiles in pixels
//  PREVIEW_OFS    40   pixel distance from preview row top to grid row-0 tile top
//  STEP_PX        17   animation advance per step, in pixels
//  STEP_FRAMES    2    frames per animation step (>=1)
// PORTS
//  mastClk        in   1   system clock
//  rst            in   1   synchronous active-high reset
//  hCount         in   10  VGA horizontal counter
//  vCount         in   10  VGA vertical counter
//  commit_req     in   1   core requests a board commit; level, held until commit_ack
//  drop_en        in   1   request is a drop move (animate); sampled with accept
//  drop_row       in   2   final row of the dropped tile; sampled with accept
//  board_in       in   80  core board, 16 x 5-bit log2 codes, cell (r,c) at [(r*4+c)*5 +: 5]
//  spawn_in       in   5   next spawn value code
//  cursor_col_in  in   2   drop column
//  commit_ack     out  1   one-cycle pulse: snapshot is now displayed
//  board_disp     out  80  board shown by the renderer
//  spawn_disp     out  5   preview value shown by the renderer
//  anim_active    out  1   a fall animation is in progress
//  anim_col       out  2   column of the falling tile
//  anim_val       out  5   value code of the falling tile
//  anim_y_off     out  10  pixel offset of the falling tile below the preview row
//  frame_tick     out  1   one-cycle pulse at vblank start
// BEHAVIOUR
//  Reset (synchronous): state IDLE, board_disp=0, spawn_disp=5'd1, all other outputs 0, frame divider 0.
//  frame_tick is registered. It is 1 in the cycle after hCount==0 && vCount==V_ACTIVE is sampled, so it pulses exactly once per frame.
//  target = PREVIEW_OFS + drop_row*(TILE_SIZE+GAP_SIZE), computed in 10 bits; the maximum is 142.
//  States:
//   IDLE: when commit_req=1, latch board_in, spawn_in, cursor_col_in, drop_row and the falling value.
//    The falling value is the spawn_disp value at accept.
//    If drop_en=1 and the falling value != 0: go to ANIM with anim_active=1, anim_y_off=0 and divider=0.
//    Otherwise go to WAIT_VBL.
//   ANIM: the divider counts frame_ticks, 0..STEP_FRAMES-1.
//    On the tick where the divider wraps, anim_y_off += STEP_PX, saturating at target.
//    When anim_y_off reaches target, go to WAIT_VBL. anim_active stays 1 there.
//   WAIT_VBL: on the next frame_tick, board_disp<=latched board, spawn_disp<=latched spawn, anim_active<=0, anim_y_off<=0; go to ACK.
//   ACK: commit_ack=1 for exactly one cycle; go to IDLE.
//  Handshake:
//   The core drops commit_req on the edge where it samples commit_ack=1.
//   IDLE samples commit_req no earlier than one cycle after ACK, so one request yields one ack.
//   commit_req changes before ack are ignored. The latched snapshot is never re-sampled mid-operation.
//  Latency:
//   Non-drop: accept -> board_disp update at the first frame_tick strictly after accept (<= 1 frame); ack follows 1 cycle later.
//   Drop: the N = ceil(target/STEP_PX) animation steps take N*STEP_FRAMES frame_ticks, then +1 frame for the commit.
//  Simultaneous events: commit_req accepted in the same cycle as frame_tick does NOT commit on that tick; it waits for the next one.
//  drop_row=0 gives target=40, so 3 steps of 17 (17, 34, 40 saturated).
//  board_disp and spawn_disp change only in the WAIT_VBL->ACK transition, i.e. during blanking. They never tear.
//  Reset mid-ANIM or mid-WAIT_VBL: abandon the operation, no ack, outputs return to reset values.
// STRUCTURE
//  Shared package (game_pkg): state encoding (IDLE/ANIM/WAIT_VBL/ACK), TILE_SIZE, GAP_SIZE, BOARD_W=80, code width=5.
//  Sub-module: vga_frame_tick (vblank-start detector + STEP_FRAMES divider). Outputs frame_tick and step_tick.
//  FSM, snapshot registers and the animation offset stay in this module.
// TESTING
//  1. Non-drop: board_in=80'h1, commit_req at vCount=100.
//     board_disp updates 1 cycle after the sample at vCount=480/hCount=0; commit_ack follows 1 cycle later; no earlier change.
//  2. Drop, drop_row=3, spawn_disp=1, STEP_FRAMES=2: anim_y_off goes 17, 34, ..., 136, 142 over 9 steps (18 ticks).
//     Commit on the next tick; anim_active then 0.
//  3. commit_req rising in the same cycle as frame_tick: commit is deferred exactly one frame.
//  4. board_in changed every cycle after accept: board_disp equals the accept-cycle value.
//  5. rst asserted mid-ANIM: next cycle board_disp=0, spawn_disp=1, anim_active=0, no commit_ack ever pulses.
//  6. Back-to-back: core re-raises commit_req 2 cycles after ack: a second accept and a second single ack, one per frame.

Source files
------------

// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Definitions shared by the board commit path:
//   - commit_state_t : commit scheduler state encoding
//   - TILE_SIZE / GAP_SIZE : tile geometry in pixels
//   - BOARD_W / CODE_W : packed board width and per-cell log2 code width
//   - drop_target() : pixel offset of a grid row below the preview row
// ---------------------------------------------------------------------------
package game_pkg;

    localparam int TILE_SIZE = 30;
    localparam int GAP_SIZE  = 4;
    localparam int BOARD_W   = 80;
    localparam int CODE_W    = 5;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ANIM     = 2'd1,
        ST_WAIT_VBL = 2'd2,
        ST_ACK      = 2'd3
    } commit_state_t;

    // Distance from the preview row top to the top of grid row 'row'.
    // Row 3 with the default geometry gives 142, well inside 10 bits.
    function automatic logic [9:0] drop_target(input logic [1:0] row,
                                               input int         preview_ofs,
                                               input int         row_pitch);
        return 10'(preview_ofs) + 10'(row) * 10'(row_pitch);
    endfunction

endpackage

// File: rtl/vga_frame_tick.sv
// ---------------------------------------------------------------------------
// vga_frame_tick
// Detects the start of vertical blanking and divides frames into animation
// steps.
//   mastClk     in   system clock
//   rst         in   synchronous active-high reset
//   hCount      in   VGA horizontal counter
//   vCount      in   VGA vertical counter
//   div_clr     in   hold the frame divider at 0
//   frame_tick  out  registered one-cycle pulse, once per frame at vblank start
//   step_tick   out  frame_tick on which the divider wraps (every STEP_FRAMES)
// ---------------------------------------------------------------------------
module vga_frame_tick #(
    parameter int V_ACTIVE    = 480,
    parameter int STEP_FRAMES = 2
) (
    input  logic       mastClk,
    input  logic       rst,
    input  logic [9:0] hCount,
    input  logic [9:0] vCount,
    input  logic       div_clr,
    output logic       frame_tick,
    output logic       step_tick
);

    localparam int DIV_W = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_FRAMES - 1);

    logic             frame_tick_reg;
    logic [DIV_W-1:0] div_reg;

    always_ff @(posedge mastClk) begin
        if (rst) begin
            frame_tick_reg <= 1'b0;
            div_reg        <= '0;
        end else begin
            // (0, V_ACTIVE) occurs for exactly one cycle per frame
            frame_tick_reg <= (hCount == 10'd0) && (vCount == 10'(V_ACTIVE));
            if (div_clr) begin
                div_reg <= '0;
            end else if (frame_tick_reg) begin
                div_reg <= (div_reg == DIV_LAST) ? '0 : div_reg + DIV_W'(1);
            end
        end
    end

    assign frame_tick = frame_tick_reg;
    assign step_tick  = frame_tick_reg && (div_reg == DIV_LAST);

endmodule

// File: rtl/board_commit_scheduler.sv
// ---------------------------------------------------------------------------
// board_commit_scheduler
// Sequences board updates from the game core into the renderer so that the
// displayed board only changes during vertical blanking. Drop moves first
// play a frame-stepped fall animation of the spawned tile.
//   mastClk        in   system clock
//   rst            in   synchronous active-high reset
//   hCount/vCount  in   VGA counters
//   commit_req     in   level request, held by the core until commit_ack
//   drop_en        in   request is a drop move (sampled at accept)
//   drop_row       in   final row of the dropped tile (sampled at accept)
//   board_in       in   16 x 5-bit board, cell (r,c) at [(r*4+c)*5 +: 5]
//   spawn_in       in   next spawn value code
//   cursor_col_in  in   drop column
//   commit_ack     out  one-cycle pulse once the snapshot is displayed
//   board_disp     out  board shown by the renderer
//   spawn_disp     out  preview value shown by the renderer
//   anim_active    out  fall animation in progress
//   anim_col/val   out  column and value code of the falling tile
//   anim_y_off     out  falling tile offset below the preview row, pixels
//   frame_tick     out  one-cycle pulse at vblank start
// ---------------------------------------------------------------------------
module board_commit_scheduler
    import game_pkg::*;
#(
    parameter int V_ACTIVE    = 480,
    parameter int TILE_SIZE   = game_pkg::TILE_SIZE,
    parameter int GAP_SIZE    = game_pkg::GAP_SIZE,
    parameter int PREVIEW_OFS = 40,
    parameter int STEP_PX     = 17,
    parameter int STEP_FRAMES = 2
) (
    input  logic               mastClk,
    input  logic               rst,
    input  logic [9:0]         hCount,
    input  logic [9:0]         vCount,
    input  logic               commit_req,
    input  logic               drop_en,
    input  logic [1:0]         drop_row,
    input  logic [BOARD_W-1:0] board_in,
    input  logic [CODE_W-1:0]  spawn_in,
    input  logic [1:0]         cursor_col_in,
    output logic               commit_ack,
    output logic [BOARD_W-1:0] board_disp,
    output logic [CODE_W-1:0]  spawn_disp,
    output logic               anim_active,
    output logic [1:0]         anim_col,
    output logic [CODE_W-1:0]  anim_val,
    output logic [9:0]         anim_y_off,
    output logic               frame_tick
);

    commit_state_t      state_reg;
    logic [BOARD_W-1:0] board_lat_reg;
    logic [CODE_W-1:0]  spawn_lat_reg;
    logic [9:0]         target_reg;
    logic [BOARD_W-1:0] board_disp_reg;
    logic [CODE_W-1:0]  spawn_disp_reg;
    logic               commit_ack_reg;
    logic               anim_active_reg;
    logic [1:0]         anim_col_reg;
    logic [CODE_W-1:0]  anim_val_reg;
    logic [9:0]         anim_y_off_reg;

    logic               frame_tick_w;
    logic               step_tick_w;
    logic [9:0]         y_next;

    vga_frame_tick #(
        .V_ACTIVE    (V_ACTIVE),
        .STEP_FRAMES (STEP_FRAMES)
    ) u_frame_tick (
        .mastClk    (mastClk),
        .rst        (rst),
        .hCount     (hCount),
        .vCount     (vCount),
        .div_clr    (state_reg != ST_ANIM),
        .frame_tick (frame_tick_w),
        .step_tick  (step_tick_w)
    );

    assign y_next = anim_y_off_reg + 10'(STEP_PX);

    always_ff @(posedge mastClk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            board_lat_reg   <= '0;
            spawn_lat_reg   <= '0;
            target_reg      <= '0;
            board_disp_reg  <= '0;
            spawn_disp_reg  <= CODE_W'(1);
            commit_ack_reg  <= 1'b0;
            anim_active_reg <= 1'b0;
            anim_col_reg    <= '0;
            anim_val_reg    <= '0;
            anim_y_off_reg  <= '0;
        end else begin
            commit_ack_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    // While the ack pulse is visible the core still holds the
                    // old request; ignoring it keeps one ack per request.
                    if (commit_req && !commit_ack_reg) begin
                        board_lat_reg <= board_in;
                        spawn_lat_reg <= spawn_in;
                        target_reg    <= drop_target(drop_row, PREVIEW_OFS,
                                                     TILE_SIZE + GAP_SIZE);
                        anim_col_reg  <= cursor_col_in;
                        anim_val_reg  <= spawn_disp_reg;
                        if (drop_en && (spawn_disp_reg != '0)) begin
                            anim_active_reg <= 1'b1;
                            anim_y_off_reg  <= '0;
                            state_reg       <= ST_ANIM;
                        end else begin
                            state_reg <= ST_WAIT_VBL;
                        end
                    end
                end
                ST_ANIM: begin
                    if (step_tick_w) begin
                        if (y_next >= target_reg) begin
                            anim_y_off_reg <= target_reg;
                            state_reg      <= ST_WAIT_VBL;
                        end else begin
                            anim_y_off_reg <= y_next;
                        end
                    end
                end
                ST_WAIT_VBL: begin
                    // The tile stays drawn at its landing spot until the
                    // board containing it is swapped in.
                    if (frame_tick_w) begin
                        board_disp_reg  <= board_lat_reg;
                        spawn_disp_reg  <= spawn_lat_reg;
                        anim_active_reg <= 1'b0;
                        anim_y_off_reg  <= '0;
                        state_reg       <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    commit_ack_reg <= 1'b1;
                    state_reg      <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign commit_ack  = commit_ack_reg;
    assign board_disp  = board_disp_reg;
    assign spawn_disp  = spawn_disp_reg;
    assign anim_active = anim_active_reg;
    assign anim_col    = anim_col_reg;
    assign anim_val    = anim_val_reg;
    assign anim_y_off  = anim_y_off_reg;
    assign frame_tick  = frame_tick_w;

endmodule

// File: tb/tb_board_commit_scheduler.sv
// ---------------------------------------------------------------------------
// tb_board_commit_scheduler
// Randomized and directed commits checked against a frame-counting model:
// a commit lands on the (2*ceil(target/17)+1)-th vblank after accept for an
// animated drop, on the first vblank after accept otherwise, with the fall
// offset at min(17*floor(ticks/2), target) in between.
// The VGA counters are compressed (hCount 0..1, vCount 0..488 step 4) so a
// frame is 246 cycles while still crossing vCount 100 and 480.
// ---------------------------------------------------------------------------
module tb_board_commit_scheduler;

    localparam int H_TOTAL = 2;
    localparam int V_STEP  = 4;
    localparam int V_LAST  = 488;
    localparam int FRAME   = H_TOTAL * (V_LAST / V_STEP + 1);
    localparam int BUDGET  = 40 * FRAME;

    logic        mastClk;
    logic        rst;
    logic [9:0]  hCount;
    logic [9:0]  vCount;
    logic        commit_req;
    logic        drop_en;
    logic [1:0]  drop_row;
    logic [79:0] board_in;
    logic [4:0]  spawn_in;
    logic [1:0]  cursor_col_in;
    logic        commit_ack;
    logic [79:0] board_disp;
    logic [4:0]  spawn_disp;
    logic        anim_active;
    logic [1:0]  anim_col;
    logic [4:0]  anim_val;
    logic [9:0]  anim_y_off;
    logic        frame_tick;

    int          n_checks = 0;
    int          n_fail   = 0;
    bit          tick_now;
    logic [79:0] m_board;
    logic [4:0]  m_spawn;

    board_commit_scheduler dut (
        .mastClk       (mastClk),
        .rst           (rst),
        .hCount        (hCount),
        .vCount        (vCount),
        .commit_req    (commit_req),
        .drop_en       (drop_en),
        .drop_row      (drop_row),
        .board_in      (board_in),
        .spawn_in      (spawn_in),
        .cursor_col_in (cursor_col_in),
        .commit_ack    (commit_ack),
        .board_disp    (board_disp),
        .spawn_disp    (spawn_disp),
        .anim_active   (anim_active),
        .anim_col      (anim_col),
        .anim_val      (anim_val),
        .anim_y_off    (anim_y_off),
        .frame_tick    (frame_tick)
    );

    initial begin
        mastClk = 1'b0;
        forever #5 mastClk = ~mastClk;
    end

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [79:0] rand_board();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[79:0];
    endfunction

    // Advance to the next falling edge. The counters now hold what the DUT
    // sampled at the rising edge just passed, so a vblank-start match there
    // means frame_tick must be high in this cycle.
    task automatic step();
        @(negedge mastClk);
        tick_now = (hCount == 10'd0) && (vCount == 10'd480);
        if (!rst) check("frame_tick", 80'(frame_tick), 80'(tick_now));
        if (int'(hCount) == H_TOTAL - 1) begin
            hCount = 10'd0;
            vCount = (int'(vCount) >= V_LAST) ? 10'd0 : vCount + 10'(V_STEP);
        end else begin
            hCount = hCount + 10'd1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            check("idle_ack", 80'(commit_ack), 80'd0);
            check("idle_board", board_disp, m_board);
        end
    endtask

    task automatic scramble();
        board_in      = rand_board();
        spawn_in      = 5'($urandom());
        drop_en       = 1'($urandom());
        drop_row      = 2'($urandom());
        cursor_col_in = 2'($urandom());
    endtask

    // One full request/ack handshake, driven from the current falling edge.
    task automatic txn(input bit drop, input logic [1:0] row, input logic [1:0] col,
                       input logic [79:0] board, input logic [4:0] spawn);
        logic [4:0] fall;
        bit         anim;
        int         target, steps, need, ticks, cyc, exp_y;
        fall   = m_spawn;
        anim   = drop && (fall != 5'd0);
        target = 40 + int'(row) * 34;
        steps  = (target + 16) / 17;
        need   = anim ? steps * 2 + 1 : 1;
        commit_req    = 1'b1;
        drop_en       = drop;
        drop_row      = row;
        board_in      = board;
        spawn_in      = spawn;
        cursor_col_in = col;
        ticks = 0;
        cyc   = 0;
        while (ticks < need && cyc < BUDGET) begin
            step();
            cyc++;
            exp_y = anim ? ((17 * (ticks / 2) < target) ? 17 * (ticks / 2) : target) : 0;
            check("anim_active", 80'(anim_active), 80'(anim));
            check("anim_y_off", 80'(anim_y_off), 80'(exp_y));
            check("board_hold", board_disp, m_board);
            check("spawn_hold", 80'(spawn_disp), 80'(m_spawn));
            check("early_ack", 80'(commit_ack), 80'd0);
            if (anim) begin
                check("anim_col", 80'(anim_col), 80'(col));
                check("anim_val", 80'(anim_val), 80'(fall));
            end
            if (tick_now) ticks++;
            scramble();
        end
        if (ticks < need) begin
            check("commit_timeout", 80'(ticks), 80'(need));
            commit_req = 1'b0;
            return;
        end
        m_board = board;
        m_spawn = spawn;
        step();
        check("board_commit", board_disp, m_board);
        check("spawn_commit", 80'(spawn_disp), 80'(m_spawn));
        check("anim_off_after", 80'(anim_active), 80'd0);
        check("y_off_after", 80'(anim_y_off), 80'd0);
        check("ack_not_yet", 80'(commit_ack), 80'd0);
        step();
        check("ack_pulse", 80'(commit_ack), 80'd1);
        // The core sees the ack at the coming edge and drops its request
        // just after it.
        step();
        commit_req = 1'b0;
        check("ack_single", 80'(commit_ack), 80'd0);
        $display("txn drop=%0d row=%0d col=%0d fall=%0d ticks=%0d spawn=%0d board=%h",
                 drop, row, col, fall, need, spawn, board);
    endtask

    initial begin
        int  cnt, ticks;
        bit  d;
        logic [4:0] sp;
        rst           = 1'b1;
        hCount        = 10'd0;
        vCount        = 10'd0;
        commit_req    = 1'b0;
        drop_en       = 1'b0;
        drop_row      = 2'd0;
        board_in      = '0;
        spawn_in      = 5'd0;
        cursor_col_in = 2'd0;
        m_board       = '0;
        m_spawn       = 5'd1;
        repeat (3) step();
        check("rst_board", board_disp, 80'd0);
        check("rst_spawn", 80'(spawn_disp), 80'd1);
        check("rst_ack", 80'(commit_ack), 80'd0);
        check("rst_anim", 80'(anim_active), 80'd0);
        check("rst_y_off", 80'(anim_y_off), 80'd0);
        check("rst_col", 80'(anim_col), 80'd0);
        check("rst_val", 80'(anim_val), 80'd0);
        check("rst_tick", 80'(frame_tick), 80'd0);
        rst = 1'b0;
        idle(4);

        // Non-drop commit requested at vCount 100
        cnt = 0;
        while (!(vCount == 10'd100 && hCount == 10'd0) && cnt < BUDGET) begin
            step();
            cnt++;
        end
        txn(1'b0, 2'd0, 2'd0, 80'h1, 5'd1);

        // Full-height drop of value 1: nine steps, commit on the 19th tick
        idle(5);
        txn(1'b1, 2'd3, 2'd2, rand_board(), 5'd2);

        // Request accepted in the frame_tick cycle waits a whole frame
        idle(3);
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (!tick_now && cnt < BUDGET);
        txn(1'b0, 2'd1, 2'd1, rand_board(), 5'd3);

        // Back-to-back: second request raised two cycles after the ack
        txn(1'b1, 2'd0, 2'd3, rand_board(), 5'd4);
        step();
        txn(1'b0, 2'd2, 2'd0, rand_board(), 5'd5);

        // Reset while the fall animation is running
        idle(2);
        commit_req    = 1'b1;
        drop_en       = 1'b1;
        drop_row      = 2'd2;
        board_in      = rand_board();
        spawn_in      = 5'd7;
        cursor_col_in = 2'd1;
        ticks = 0;
        cnt   = 0;
        while (ticks < 3 && cnt < BUDGET) begin
            step();
            cnt++;
            if (tick_now) ticks++;
        end
        check("rst_mid_anim_active", 80'(anim_active), 80'd1);
        rst = 1'b1;
        step();
        check("mid_rst_board", board_disp, 80'd0);
        check("mid_rst_spawn", 80'(spawn_disp), 80'd1);
        check("mid_rst_anim", 80'(anim_active), 80'd0);
        check("mid_rst_y_off", 80'(anim_y_off), 80'd0);
        check("mid_rst_ack", 80'(commit_ack), 80'd0);
        rst        = 1'b0;
        commit_req = 1'b0;
        m_board    = '0;
        m_spawn    = 5'd1;
        $display("reset during animation after %0d ticks", ticks);
        idle(2 * FRAME);

        // Randomized traffic, including zero spawn values that suppress animation
        for (int i = 0; i < 8; i++) begin
            idle($urandom_range(0, FRAME));
            d  = 1'($urandom());
            sp = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 11));
            txn(d, 2'($urandom()), 2'($urandom()), rand_board(), sp);
        end
        idle(FRAME + 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
